// File: rtl/hp_mon_pkg.sv
// Shared definitions for the multi-channel alarm monitor: register offsets,
// bit positions inside STATUS/CTRL/EVENT, the default clear key and the event
// FIFO entry layout.
package hp_mon_pkg;

  // Register byte offsets relative to BASE_ADDRESS
  localparam logic [31:0] OFF_CTRL     = 32'h0000_0000;
  localparam logic [31:0] OFF_STATUS   = 32'h0000_0004;
  localparam logic [31:0] OFF_CLEAR    = 32'h0000_0008;
  localparam logic [31:0] OFF_EVENT    = 32'h0000_000C;
  localparam logic [31:0] OFF_CNT_BASE = 32'h0000_0010;

  // CTRL bit positions
  localparam int CTRL_IRQ_EN_BIT = 16;

  // STATUS bit positions
  localparam int ST_FIFO_EMPTY_BIT = 16;
  localparam int ST_FIFO_FULL_BIT  = 17;
  localparam int ST_OVERFLOW_BIT   = 18;

  // CLEAR bit positions
  localparam int CLR_OVF_BIT = 15;

  // EVENT word bit positions
  localparam int EV_VALID_BIT = 31;
  localparam int EV_MULTI_BIT = 30;
  localparam int EV_CH_LSB    = 24;

  // Key expected in dat_i[31:16] of a CLEAR write
  localparam logic [15:0] DEFAULT_CLR_KEY = 16'hC1EA;

  // One logged alarm event; timestamp is stored zero-extended to 24 bits
  typedef struct packed {
    logic       multi;
    logic [5:0] channel;
    logic [23:0] ts;
  } ev_entry_t;

  localparam int EV_ENTRY_W = $bits(ev_entry_t);

  // Width of a stored event entry
  function automatic int ev_entry_width();
    return $bits(ev_entry_t);
  endfunction

  // Format a stored entry as the EVENT register read word (valid bit set)
  function automatic logic [31:0] ev_to_word(input ev_entry_t e);
    return {1'b1, e.multi, e.channel, e.ts};
  endfunction

endpackage

// File: rtl/hp_event_fifo.sv
// Synchronous show-ahead FIFO. A push while full is accepted only when a pop
// happens in the same cycle; a pop while empty is ignored.
import hp_mon_pkg::*;

module hp_event_fifo #(
  parameter int WIDTH = EV_ENTRY_W,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);
  assign dout      = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update; extra MSB distinguishes full from empty
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage write; cleared on reset so stale entries never reappear
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/hp_alarm_monitor.sv
// Multi-channel alarm monitor: per-channel synchronizer, edge detect, sticky
// latch and saturating counter, a timestamped event FIFO, a wishbone register
// block and a level interrupt.
module hp_alarm_monitor
  import hp_mon_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
  parameter int          NUM_CH       = 4,
  parameter int          CTR_W        = 8,
  parameter int          TS_W         = 24,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [15:0] CLR_KEY      = DEFAULT_CLR_KEY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] alarm_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              irq_o
);

  localparam logic [31:0]       LAST_OFF = OFF_CNT_BASE + 32'(4 * (NUM_CH - 1));
  localparam logic [CTR_W-1:0]  CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0]  CTR_ONE  = CTR_W'(1);
  localparam logic [TS_W-1:0]   TS_ONE   = TS_W'(1);
  localparam logic [NUM_CH-1:0] CH_ONE   = NUM_CH'(1);

  // Capture path
  logic [NUM_CH-1:0] sync1_r;
  logic [NUM_CH-1:0] sync2_r;
  logic [NUM_CH-1:0] sync3_r;
  logic [NUM_CH-1:0] ev_r;

  // State
  logic [TS_W-1:0]   ts_r;
  logic [NUM_CH-1:0] en_r;
  logic              irq_en_r;
  logic [NUM_CH-1:0] latch_r;
  logic [CTR_W-1:0]  cnt_r [NUM_CH];
  logic              overflow_r;

  // Bus decode
  logic [31:0]       offset_s;
  logic              acc_s;
  logic              wr_s;
  logic              rd_s;
  logic              clr_s;
  logic [NUM_CH-1:0] clr_ch_s;
  logic              clr_ovf_s;
  logic [31:0]       rdata_s;
  logic [31:0]       cnt_sel_s;
  logic              dat_unused_s;

  // Event logging
  logic [NUM_CH-1:0] ev_en_s;
  logic              push_s;
  logic              pop_s;
  logic              drop_s;
  logic [5:0]        ch_s;
  logic              multi_s;
  ev_entry_t         fifo_din_s;
  ev_entry_t         fifo_dout_s;
  logic [EV_ENTRY_W-1:0] fifo_dout_raw_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;

  assign offset_s     = wbs_adr_i - BASE_ADDRESS;
  assign acc_s        = wbs_cyc_i & wbs_stb_i & (offset_s <= LAST_OFF);
  assign wr_s         = acc_s & wbs_we_i;
  assign rd_s         = acc_s & ~wbs_we_i;
  assign clr_s        = wr_s & (offset_s == OFF_CLEAR) & (wbs_dat_i[31:16] == CLR_KEY);
  assign clr_ch_s     = clr_s ? wbs_dat_i[NUM_CH-1:0] : {NUM_CH{1'b0}};
  assign clr_ovf_s    = clr_s & wbs_dat_i[CLR_OVF_BIT];
  assign dat_unused_s = ^wbs_dat_i[14:0];

  assign ev_en_s = ev_r & en_r;
  assign push_s  = |ev_en_s;
  assign pop_s   = rd_s & (offset_s == OFF_EVENT) & ~fifo_empty_s;
  assign drop_s  = push_s & fifo_full_s & ~pop_s;

  assign fifo_dout_s = ev_entry_t'(fifo_dout_raw_s);

  // Two-flop synchronizer, third flop for edge detect, registered event pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= {NUM_CH{1'b0}};
      sync2_r <= {NUM_CH{1'b0}};
      sync3_r <= {NUM_CH{1'b0}};
      ev_r    <= {NUM_CH{1'b0}};
    end else begin
      sync1_r <= alarm_i;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
      ev_r    <= sync2_r & ~sync3_r;
    end
  end

  // Free-running wrapping timestamp
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_r <= {TS_W{1'b0}};
    end else begin
      ts_r <= ts_r + TS_ONE;
    end
  end

  // Lowest-index firing channel and multiple-fire flag for the FIFO entry
  always_comb begin
    ch_s    = 6'd0;
    multi_s = |(ev_en_s & (ev_en_s - CH_ONE));
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ev_en_s[i]) begin
        ch_s = 6'(i);
      end else begin
        ch_s = ch_s;
      end
    end
    fifo_din_s.multi   = multi_s;
    fifo_din_s.channel = ch_s;
    fifo_din_s.ts      = 24'(ts_r);
  end

  hp_event_fifo #(
    .WIDTH(EV_ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push_s),
    .pop  (pop_s),
    .din  (fifo_din_s),
    .dout (fifo_dout_raw_s),
    .empty(fifo_empty_s),
    .full (fifo_full_s)
  );

  // CTRL register: channel enables and interrupt enable
  always_ff @(posedge clk) begin
    if (reset) begin
      en_r     <= {NUM_CH{1'b0}};
      irq_en_r <= 1'b0;
    end else if (wr_s && (offset_s == OFF_CTRL)) begin
      en_r     <= wbs_dat_i[NUM_CH-1:0];
      irq_en_r <= wbs_dat_i[CTRL_IRQ_EN_BIT];
    end
  end

  // Per-channel latch and saturating counter; an event beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      latch_r <= {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_r[i] <= {CTR_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ev_en_s[i]) begin
          latch_r[i] <= 1'b1;
          if (clr_ch_s[i]) begin
            cnt_r[i] <= CTR_ONE;
          end else if (cnt_r[i] != CTR_MAX) begin
            cnt_r[i] <= cnt_r[i] + CTR_ONE;
          end
        end else if (clr_ch_s[i]) begin
          latch_r[i] <= 1'b0;
          cnt_r[i]   <= {CTR_W{1'b0}};
        end
      end
    end
  end

  // Sticky FIFO overflow flag; a dropped push wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (clr_ovf_s) begin
      overflow_r <= 1'b0;
    end
  end

  // Read data mux; zero for writes, misses and idle cycles
  always_comb begin
    rdata_s   = 32'd0;
    cnt_sel_s = 32'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_sel_s = cnt_sel_s |
                  ((offset_s == (OFF_CNT_BASE + 32'(4 * i))) ? 32'(cnt_r[i]) : 32'd0);
    end
    if (rd_s) begin
      case (offset_s)
        OFF_CTRL: begin
          rdata_s[NUM_CH-1:0]      = en_r;
          rdata_s[CTRL_IRQ_EN_BIT] = irq_en_r;
        end
        OFF_STATUS: begin
          rdata_s[NUM_CH-1:0]        = latch_r;
          rdata_s[ST_FIFO_EMPTY_BIT] = fifo_empty_s;
          rdata_s[ST_FIFO_FULL_BIT]  = fifo_full_s;
          rdata_s[ST_OVERFLOW_BIT]   = overflow_r;
        end
        OFF_EVENT: begin
          rdata_s = fifo_empty_s ? 32'd0 : ev_to_word(fifo_dout_s);
        end
        default: begin
          rdata_s = cnt_sel_s;
        end
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  // Wishbone response: one-cycle ack with registered data
  always_ff @(posedge clk) begin
    if (reset) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'd0;
    end else begin
      wbs_ack_o <= acc_s;
      wbs_dat_o <= rdata_s;
    end
  end

  // Registered level interrupt
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= irq_en_r & ((|latch_r) | overflow_r);
    end
  end

endmodule

// File: tb/tb_hp_alarm_monitor.sv
// Directed bench for hp_alarm_monitor. Bus reads push their expected word into
// a scoreboard queue; a monitor on the falling edge pops and compares on ack.
module tb_hp_alarm_monitor;

  localparam logic [31:0] BASE    = 32'h3000_0000;
  localparam logic [31:0] O_CTRL  = 32'h00;
  localparam logic [31:0] O_STAT  = 32'h04;
  localparam logic [31:0] O_CLR   = 32'h08;
  localparam logic [31:0] O_EVT   = 32'h0C;
  localparam logic [31:0] O_CNT0  = 32'h10;
  localparam logic [31:0] O_CNT1  = 32'h14;
  localparam logic [31:0] O_CNT2  = 32'h18;
  localparam logic [31:0] O_CNT3  = 32'h1C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  alarm = 4'h0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [31:0] adr = 32'd0;
  logic [31:0] wdat = 32'd0;
  logic        ack;
  logic [31:0] rdat;
  logic        irq;

  int checks = 0;
  int passes = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [23:0] tb_ts;

  always #5 clk = ~clk;

  hp_alarm_monitor dut (
    .clk      (clk),
    .reset    (reset),
    .alarm_i  (alarm),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_ack_o(ack),
    .wbs_dat_o(rdat),
    .irq_o    (irq)
  );

  // Reference timestamp: cycles elapsed since reset released
  always @(posedge clk) begin
    if (reset) tb_ts <= 24'd0;
    else       tb_ts <= tb_ts + 24'd1;
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [31:0] e;
    string n;
    if (ack) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_ack: got ack with data %h, required no ack", rdat);
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (rdat === e) passes++;
        else $display("FAIL %s: got %h, required %h", n, rdat, e);
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] e);
    checks++;
    if (act === e) passes++;
    else $display("FAIL %s: got %h, required %h", n, act, e);
  endtask

  task automatic wb_access(input logic w, input logic [31:0] off, input logic [31:0] d);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = BASE + off; wdat = d;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; wdat = 32'd0;
  endtask

  task automatic rd(input logic [31:0] off, input logic [31:0] e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
    wb_access(1'b0, off, 32'd0);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    exp_q.push_back(32'd0);
    name_q.push_back("write_ack_data");
    wb_access(1'b1, off, d);
  endtask

  // One-cycle alarm pulse; returns the timestamp expected in its FIFO entry
  task automatic pulse(input logic [3:0] m, output logic [23:0] ts_exp);
    @(negedge clk);
    alarm = m;
    ts_exp = tb_ts + 24'd3;
    @(negedge clk);
    alarm = 4'h0;
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [23:0] t;
    logic [23:0] ts8 [8];

    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("irq_reset", {31'd0, irq}, 32'd0);
    rd(O_CTRL, 32'h0000_0000, "ctrl_reset");
    rd(O_STAT, 32'h0001_0000, "status_reset");
    rd(O_EVT,  32'h0000_0000, "event_reset");
    rd(O_CNT0, 32'h0000_0000, "cnt0_reset");

    // Address beyond the last counter is not acked
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h20;
    @(negedge clk);
    chk("miss_no_ack", {31'd0, ack}, 32'd0);
    cyc = 1'b0; stb = 1'b0;

    // Test 1: single pulse on ch2
    wr(O_CTRL, 32'h0000_000F);
    rd(O_CTRL, 32'h0000_000F, "ctrl_readback");
    pulse(4'b0100, t);
    settle();
    rd(O_CNT2, 32'h0000_0001, "t1_cnt2");
    rd(O_STAT, 32'h0000_0004, "t1_status");
    rd(O_EVT,  32'h8200_0000 | {8'd0, t}, "t1_event");
    rd(O_EVT,  32'h0000_0000, "t1_event_empty");
    rd(O_STAT, 32'h0001_0004, "t1_status_after_pop");
    wr(O_CLR, 32'hC1EA_0004);
    rd(O_STAT, 32'h0001_0000, "t1_status_cleared");

    // Test 3: ch1 and ch3 together
    pulse(4'b1010, t);
    settle();
    rd(O_EVT,  32'hC100_0000 | {8'd0, t}, "t3_event_multi");
    rd(O_EVT,  32'h0000_0000, "t3_event_empty");
    rd(O_CNT1, 32'h0000_0001, "t3_cnt1");
    rd(O_CNT3, 32'h0000_0001, "t3_cnt3");
    rd(O_STAT, 32'h0001_000A, "t3_status");

    // Test 4: keyed and unkeyed clears, clear colliding with an event
    wr(O_CLR, 32'h0000_0002);
    rd(O_CNT1, 32'h0000_0001, "t4_nokey_cnt1");
    rd(O_STAT, 32'h0001_000A, "t4_nokey_status");
    wr(O_CLR, 32'hC1EA_0002);
    rd(O_CNT1, 32'h0000_0000, "t4_key_cnt1");
    rd(O_STAT, 32'h0001_0008, "t4_key_status");
    @(negedge clk);
    alarm = 4'b0010;
    t = tb_ts + 24'd3;
    @(negedge clk);
    alarm = 4'h0;
    @(negedge clk);
    wr(O_CLR, 32'hC1EA_0002);
    settle();
    rd(O_CNT1, 32'h0000_0001, "t4_collide_cnt1");
    rd(O_STAT, 32'h0000_000A, "t4_collide_status");
    rd(O_EVT,  32'h8100_0000 | {8'd0, t}, "t4_collide_event");
    wr(O_CLR, 32'hC1EA_800F);
    rd(O_STAT, 32'h0001_0000, "t4_all_cleared");

    // Test 2: saturation and FIFO overflow
    for (int i = 0; i < 300; i++) begin
      pulse(4'b0001, t);
      if (i < 8) ts8[i] = t;
    end
    settle();
    rd(O_CNT0, 32'h0000_00FF, "t2_cnt0_saturated");
    rd(O_STAT, 32'h0006_0001, "t2_status_full_ovf");
    for (int i = 0; i < 8; i++) begin
      rd(O_EVT, 32'h8000_0000 | {8'd0, ts8[i]}, $sformatf("t2_event%0d", i));
    end
    rd(O_EVT,  32'h0000_0000, "t2_event_drained");
    rd(O_STAT, 32'h0005_0001, "t2_status_drained");
    wr(O_CLR, 32'hC1EA_0001);
    rd(O_STAT, 32'h0005_0000, "t2_ovf_kept_without_bit15");
    wr(O_CLR, 32'hC1EA_8000);
    rd(O_STAT, 32'h0001_0000, "t2_ovf_cleared");
    rd(O_CNT0, 32'h0000_0000, "t2_cnt0_cleared");

    // Test 5: gating and interrupt
    wr(O_CTRL, 32'h0001_0000);
    pulse(4'b0001, t);
    settle();
    rd(O_CNT0, 32'h0000_0000, "t5_gated_cnt0");
    rd(O_STAT, 32'h0001_0000, "t5_gated_status");
    chk("t5_irq_gated", {31'd0, irq}, 32'd0);
    wr(O_CTRL, 32'h0001_0001);
    rd(O_CTRL, 32'h0001_0001, "t5_ctrl");
    pulse(4'b0001, t);
    settle();
    chk("t5_irq_set", {31'd0, irq}, 32'd1);
    rd(O_CNT0, 32'h0000_0001, "t5_cnt0");
    rd(O_STAT, 32'h0000_0001, "t5_status");
    wr(O_CLR, 32'hC1EA_0001);
    chk("t5_irq_delay", {31'd0, irq}, 32'd1);
    @(negedge clk);
    chk("t5_irq_cleared", {31'd0, irq}, 32'd0);

    // Test 6: reset during a read with the FIFO non-empty
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + O_EVT; reset = 1'b1;
    @(negedge clk);
    chk("t6_ack_suppressed", {31'd0, ack}, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rd(O_CTRL, 32'h0000_0000, "t6_ctrl");
    rd(O_STAT, 32'h0001_0000, "t6_status");
    rd(O_EVT,  32'h0000_0000, "t6_event");
    rd(O_CNT0, 32'h0000_0000, "t6_cnt0");
    chk("t6_irq", {31'd0, irq}, 32'd0);

    // Drain outstanding expectations with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    while (exp_q.size() != 0) begin
      checks++;
      $display("FAIL missing_ack %s: got no ack, required %h", name_q.pop_front(), exp_q.pop_front());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
